// File: rtl/inst_sram_axi_bridge_if.sv
// Fetch-side SRAM-like request/response plus AXI4 read-address and read-data
// channels, bundled so the bridge and its neighbours share one port list.
// Modport master: the bridge (answers fetch, drives AR, sinks R).
// Modport slave: the environment (fetch stage plus AXI read arbiter/memory).
interface inst_sram_axi_bridge_if;
  // fetch side
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_en, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_en, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Purpose: turns fetch SRAM-like requests into single-beat AXI4 reads and returns data as data_ok pulses.
// Latency: addr_ok at A, arvalid at A+1, data_ok one cycle after the R beat (best case A+3).
// Backpressure: AR held until arready; addr_ok low while AR pending or MAX_OUTSTANDING reads in flight; rready always high.
// Ports: clk, rst (sync, active-high); bus (master modport): fetch en/addr/addr_ok/data_ok/rdata,
//        AXI AR channel (constant attributes, registered araddr/arvalid), AXI R channel (rid/rresp/rlast unused).
module inst_sram_axi_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID_VAL        = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_sram_axi_bridge_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arvalid_q, arvalid_d;
  logic [31:0]      araddr_q, araddr_d;
  logic             rready_q;
  logic             data_ok_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             accept;
  logic             r_hs;

  // Response attributes are not used: single beat, same ID, data forwarded regardless.
  logic unused_r_attrs;
  assign unused_r_attrs = ^{bus.rid, bus.rresp, bus.rlast};

  // Deliberately no path from arready/rvalid: a freed slot is only seen a cycle later.
  assign accept = bus.inst_sram_en & ~arvalid_q & (cnt_q < CNT_MAX) & ~rst;
  // rready is registered low through the first cycle after reset, so stale beats are dropped.
  assign r_hs   = bus.rvalid & rready_q;

  always_comb begin
    cnt_d     = cnt_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;

    if (accept && !r_hs) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!accept && r_hs && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    // accept implies arvalid_q is low, so the two branches never overlap.
    if (accept) begin
      arvalid_d = 1'b1;
      araddr_d  = bus.inst_sram_addr;
    end else if (arvalid_q && bus.arready) begin
      arvalid_d = 1'b0;
    end

    if (r_hs) begin
      rdata_d = bus.rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= 1'b1;
      data_ok_q <= r_hs;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.inst_sram_addr_ok = accept;
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;

  assign bus.arid    = ARID_VAL;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
module tb_inst_sram_axi_bridge;
  localparam int unsigned MAXO = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  inst_sram_axi_bridge_if bus ();

  inst_sram_axi_bridge #(.MAX_OUTSTANDING(MAXO), .ARID_VAL(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content the fake AXI slave returns for an address.
  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Idle fetch, let a pending AR go, then return n beats and let data_ok flush.
  task automatic drain(input int n);
    bus.inst_sram_en = 1'b0;
    bus.arready      = 1'b1;
    for (int i = 0; i < 2; i++) cyc();
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.rvalid = 1'b1;
      bus.rdata  = $urandom;
    end
    cyc();
    bus.rvalid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0000;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'hdead_beef;
    bus.rid     = 4'd0;
    bus.rresp   = 2'd0;
    bus.rlast   = 1'b1;
    cyc();
    cyc();
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok: got %b expected 0", bus.inst_sram_addr_ok); end
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_ok: got %b expected 0", bus.inst_sram_data_ok); end
    n_cmp++; if (bus.inst_sram_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", bus.inst_sram_rdata); end
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b expected 0", bus.arvalid); end
    n_cmp++; if (bus.araddr !== 32'h0) begin n_err++; $display("FAIL rst_araddr: got %h expected 0", bus.araddr); end
    n_cmp++; if (bus.rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b expected 0", bus.rready); end
    n_cmp++; if ({bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot} !== {4'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0})
      begin n_err++; $display("FAIL ar_consts: got %h/%h/%h/%h/%h/%h/%h", bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot); end
    // First cycle out of reset: a beat here must be ignored.
    cyc();
    rst = 1'b0;
    bus.inst_sram_en = 1'b0;
    settle();
    n_cmp++; if (bus.rready !== 1'b0) begin n_err++; $display("FAIL post_rst_rready: got %b expected 0", bus.rready); end
    cyc();
    bus.rvalid = 1'b0;
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL stale_beat_dropped: got %b expected 0", bus.inst_sram_data_ok); end
    n_cmp++; if (bus.rready !== 1'b1) begin n_err++; $display("FAIL rready_high: got %b expected 1", bus.rready); end
  endtask

  task automatic test_single_fetch();
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0000;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL single_addr_ok: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_en = 1'b0;
    settle();
    n_cmp++; if (bus.arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid: got %b expected 1", bus.arvalid); end
    n_cmp++; if (bus.araddr !== 32'h1c00_0000) begin n_err++; $display("FAIL single_araddr: got %h expected 1c000000", bus.araddr); end
    cyc();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0280_0c0c;
    settle();
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL single_ar_drop: got %b expected 0", bus.arvalid); end
    cyc();
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b1) begin n_err++; $display("FAIL single_data_ok: got %b expected 1", bus.inst_sram_data_ok); end
    n_cmp++; if (bus.inst_sram_rdata !== 32'h0280_0c0c) begin n_err++; $display("FAIL single_rdata: got %h expected 02800c0c", bus.inst_sram_rdata); end
    cyc();
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL single_pulse_len: got %b expected 0", bus.inst_sram_data_ok); end
    n_cmp++; if (bus.inst_sram_rdata !== 32'h0280_0c0c) begin n_err++; $display("FAIL single_rdata_held: got %h expected 02800c0c", bus.inst_sram_rdata); end
  endtask

  task automatic test_ar_backpressure();
    int hs;
    hs = 0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0100;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL bp_accept: got %b expected 1", bus.inst_sram_addr_ok); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.inst_sram_addr = 32'h1c00_0104;
      bus.arready = (i == 5);
      settle();
      n_cmp++; if (bus.arvalid !== 1'b1) begin n_err++; $display("FAIL bp_arvalid[%0d]: got %b expected 1", i, bus.arvalid); end
      n_cmp++; if (bus.araddr !== 32'h1c00_0100) begin n_err++; $display("FAIL bp_araddr[%0d]: got %h expected 1c000100", i, bus.araddr); end
      n_cmp++; if (bus.inst_sram_addr_ok !== 1'b0) begin n_err++; $display("FAIL bp_addr_ok[%0d]: got %b expected 0", i, bus.inst_sram_addr_ok); end
      if (bus.arvalid && bus.arready) hs++;
    end
    cyc();
    bus.inst_sram_en = 1'b0;
    settle();
    n_cmp++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL bp_ar_done: got %b expected 0", bus.arvalid); end
    n_cmp++; if (hs !== 1) begin n_err++; $display("FAIL bp_hs_count: got %0d expected 1", hs); end
    drain(1);
  endtask

  task automatic test_outstanding_limit();
    int acc;
    int nar;
    logic [31:0] ar_seen [4];
    acc = 0;
    nar = 0;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.inst_sram_en   = 1'b1;
      bus.inst_sram_addr = 32'h1c00_0000 + 32'(4 * acc);
      settle();
      if (bus.inst_sram_addr_ok) acc++;
      if (bus.arvalid && bus.arready && nar < 4) begin ar_seen[nar] = bus.araddr; nar++; end
    end
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL lim_accepts: got %0d expected 2", acc); end
    n_cmp++; if (nar !== 2) begin n_err++; $display("FAIL lim_ar_count: got %0d expected 2", nar); end
    n_cmp++; if (ar_seen[0] !== 32'h1c00_0000) begin n_err++; $display("FAIL lim_ar0: got %h expected 1c000000", ar_seen[0]); end
    n_cmp++; if (ar_seen[1] !== 32'h1c00_0004) begin n_err++; $display("FAIL lim_ar1: got %h expected 1c000004", ar_seen[1]); end
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b0) begin n_err++; $display("FAIL lim_full: got %b expected 0", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_addr = 32'h1c00_0008;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h0;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b0) begin n_err++; $display("FAIL lim_no_rvalid_path: got %b expected 0", bus.inst_sram_addr_ok); end
    cyc();
    bus.rvalid = 1'b0;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL lim_third_accept: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_en = 1'b0;
    settle();
    n_cmp++; if (bus.araddr !== 32'h1c00_0008 || bus.arvalid !== 1'b1) begin n_err++; $display("FAIL lim_third_ar: got %b/%h expected 1/1c000008", bus.arvalid, bus.araddr); end
    drain(2);
  endtask

  task automatic test_simultaneous();
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0200;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL sim_first: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_en = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0204;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hcafe_f00d;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL sim_accept_with_r: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_en = 1'b0;
    bus.rvalid = 1'b0;
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== 32'hcafe_f00d) begin n_err++; $display("FAIL sim_data: got %b/%h expected 1/cafef00d", bus.inst_sram_data_ok, bus.inst_sram_rdata); end
    n_cmp++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1c00_0204) begin n_err++; $display("FAIL sim_ar: got %b/%h expected 1/1c000204", bus.arvalid, bus.araddr); end
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0208;
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL sim_single_pulse: got %b expected 0", bus.inst_sram_data_ok); end
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL sim_cnt_one_accept: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_addr = 32'h1c00_020c;
    cyc();
    settle();
    n_cmp++; if (bus.arvalid !== 1'b0 || bus.inst_sram_addr_ok !== 1'b0) begin n_err++; $display("FAIL sim_cnt_full: got arvalid %b addr_ok %b expected 0/0", bus.arvalid, bus.inst_sram_addr_ok); end
    drain(2);
  endtask

  task automatic test_back_to_back();
    bus.arready = 1'b1;
    bus.rvalid  = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0300;
    cyc();
    bus.inst_sram_en = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0304;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_en = 1'b0;
    cyc();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1111_1111;
    cyc();
    bus.rdata  = 32'h2222_2222;
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_first: got %b/%h expected 1/11111111", bus.inst_sram_data_ok, bus.inst_sram_rdata); end
    cyc();
    bus.rvalid = 1'b0;
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_second: got %b/%h expected 1/22222222", bus.inst_sram_data_ok, bus.inst_sram_rdata); end
    cyc();
    settle();
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b0 || bus.inst_sram_rdata !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_end: got %b/%h expected 0/22222222", bus.inst_sram_data_ok, bus.inst_sram_rdata); end
  endtask

  task automatic test_reset_midflight();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0400;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL rmf_accept: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    rst = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0500;
    settle();
    n_cmp++; if (bus.arvalid !== 1'b1) begin n_err++; $display("FAIL rmf_pending: got %b expected 1", bus.arvalid); end
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b0) begin n_err++; $display("FAIL rmf_rst_gates_accept: got %b expected 0", bus.inst_sram_addr_ok); end
    cyc();
    rst = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hbad0_bad0;
    settle();
    n_cmp++; if (bus.arvalid !== 1'b0 || bus.inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL rmf_cleared: got arvalid %b data_ok %b expected 0/0", bus.arvalid, bus.inst_sram_data_ok); end
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL rmf_fresh_accept: got %b expected 1", bus.inst_sram_addr_ok); end
    cyc();
    bus.inst_sram_en = 1'b0;
    bus.rvalid  = 1'b0;
    bus.arready = 1'b1;
    settle();
    n_cmp++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1c00_0500) begin n_err++; $display("FAIL rmf_fresh_ar: got %b/%h expected 1/1c000500", bus.arvalid, bus.araddr); end
    n_cmp++; if (bus.inst_sram_data_ok !== 1'b0) begin n_err++; $display("FAIL rmf_beat_ignored: got %b expected 0", bus.inst_sram_data_ok); end
    cyc();
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = 32'h1c00_0504;
    settle();
    n_cmp++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_err++; $display("FAIL rmf_cnt_cleared: got %b expected 1", bus.inst_sram_addr_ok); end
    drain(2);
  endtask

  // Random fetch/AXI traffic against a queue model: accepted addresses come back
  // in order, at most MAXO unreturned, one AR in flight at a time.
  task automatic test_random();
    logic [31:0] acc_q [$];
    logic [31:0] sq [$];
    logic        m_arv;
    logic [31:0] m_araddr;
    logic        exp_dok;
    logic [31:0] exp_rdata;
    logic [31:0] pc;
    logic        exp_aok;
    logic        r_go;
    logic        ar_go;
    m_arv     = 1'b0;
    m_araddr  = 32'h0;
    exp_dok   = 1'b0;
    exp_rdata = 32'h0;
    pc        = 32'h1c00_1000;
    for (int i = 0; i < 600; i++) begin
      cyc();
      bus.inst_sram_en   = ($urandom_range(0, 3) != 0);
      bus.inst_sram_addr = pc;
      bus.arready        = 1'($urandom_range(0, 1));
      bus.rresp          = 2'($urandom_range(0, 3));
      r_go               = (sq.size() != 0) && ($urandom_range(0, 1) == 1);
      bus.rvalid         = r_go;
      bus.rdata          = r_go ? mem_of(sq[0]) : $urandom;
      settle();
      exp_aok = bus.inst_sram_en && !m_arv && (acc_q.size() < MAXO);
      n_cmp++; if (bus.inst_sram_addr_ok !== exp_aok) begin n_err++; $display("FAIL rnd_addr_ok@%0d: got %b expected %b", i, bus.inst_sram_addr_ok, exp_aok); end
      n_cmp++; if (bus.arvalid !== m_arv) begin n_err++; $display("FAIL rnd_arvalid@%0d: got %b expected %b", i, bus.arvalid, m_arv); end
      if (m_arv) begin
        n_cmp++; if (bus.araddr !== m_araddr) begin n_err++; $display("FAIL rnd_araddr@%0d: got %h expected %h", i, bus.araddr, m_araddr); end
      end
      n_cmp++; if (bus.inst_sram_data_ok !== exp_dok) begin n_err++; $display("FAIL rnd_data_ok@%0d: got %b expected %b", i, bus.inst_sram_data_ok, exp_dok); end
      if (exp_dok) begin
        n_cmp++; if (bus.inst_sram_rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata@%0d: got %h expected %h", i, bus.inst_sram_rdata, exp_rdata); end
      end
      n_cmp++; if (bus.rready !== 1'b1) begin n_err++; $display("FAIL rnd_rready@%0d: got %b expected 1", i, bus.rready); end
      // What the coming edge does.
      ar_go = m_arv && bus.arready;
      if (ar_go) sq.push_back(bus.araddr);
      if (r_go) begin
        void'(sq.pop_front());
        exp_rdata = mem_of(acc_q.pop_front());
      end
      exp_dok = r_go;
      if (exp_aok) begin
        acc_q.push_back(pc);
        m_arv    = 1'b1;
        m_araddr = pc;
        pc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hffff_fffc) : pc + 32'd4;
      end else if (ar_go) begin
        m_arv = 1'b0;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.inst_sram_en   = 1'b0;
    bus.inst_sram_addr = 32'h0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    bus.rid     = 4'd0;
    bus.rresp   = 2'd0;
    bus.rlast   = 1'b1;
    test_reset();
    test_single_fetch();
    test_ar_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
